// File: rtl/engine_result_arbiter.sv
// engine_result_arbiter: grants one engine result at a time and turns it into a single
// registered VGA RAM write, with round-robin or fixed-priority arbitration.
module engine_result_arbiter #(
    parameter int NUM_ENG = 12,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_iCLK,
    input  logic                      reset,
    input  logic [NUM_ENG-1:0]        engine_req,
    input  logic [NUM_ENG*ADDR_W-1:0] engine_addr,
    input  logic [NUM_ENG*DATA_W-1:0] engine_data,
    output logic [NUM_ENG-1:0]        req_ack,
    input  logic                      ram_busy,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data,
    output logic [CNT_W-1:0]          wr_count
);
    localparam int IDX_W = $clog2(NUM_ENG);
    localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, WAIT_RAM = 2'd2, RELEASE = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] grant_idx, last_grant, start, win;
    logic [IDX_W:0]   pos;
    logic             fire;

    assign start = (RR_MODE != 0 && last_grant != IDX_W'(NUM_ENG - 1)) ? last_grant + IDX_W'(1) : '0;
    assign fire  = (state == ACK || state == WAIT_RAM) && !ram_busy;

    // Scan downward so the last hit is the first requester at or after start.
    always_comb begin
        win = '0;
        pos = '0;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (IDX_W + 1)'(k);
            pos = (pos >= (IDX_W + 1)'(NUM_ENG)) ? pos - (IDX_W + 1)'(NUM_ENG) : pos;
            win = engine_req[pos[IDX_W-1:0]] ? pos[IDX_W-1:0] : win;
        end
    end

    always_ff @(posedge clk_iCLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ack    <= '0;
            ram_wr_en  <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            wr_count   <= '0;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_ENG - 1);
        end else begin
            ram_wr_en <= fire;
            wr_count  <= wr_count + CNT_W'(fire);
            case (state)
                IDLE: begin
                    req_ack <= (|engine_req) ? NUM_ENG'(1) << win : '0;
                    if (|engine_req) begin
                        grant_idx  <= win;
                        last_grant <= win;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    ram_addr <= engine_addr[grant_idx*ADDR_W +: ADDR_W];
                    ram_data <= engine_data[grant_idx*DATA_W +: DATA_W];
                    req_ack  <= '0;
                    state    <= ram_busy ? WAIT_RAM : RELEASE;
                end
                WAIT_RAM: state <= ram_busy ? WAIT_RAM : RELEASE;
                RELEASE:  state <= engine_req[grant_idx] ? RELEASE : IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule
